// File: rtl/stopwatch_core_pkg.sv
// Shared definitions for the lab3 stopwatch timekeeping block.
//   FW       - width of each time field
//   MAX_MIN  - highest minutes value before wrapping to 0
//   MAX_SEC  - highest seconds value before wrapping to 0
//   SEL_MIN / SEL_SEC - encoding of the select switch
//   run_state_t - run/pause state of the count FSM
package stopwatch_core_pkg;

    localparam int unsigned FW      = 6;
    localparam int unsigned MAX_MIN = 59;
    localparam int unsigned MAX_SEC = 59;

    localparam logic SEL_MIN = 1'b0;
    localparam logic SEL_SEC = 1'b1;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } run_state_t;

endpackage

// File: rtl/stopwatch_core_mod_counter.sv
// FW-bit counter that counts 0..MAX and wraps back to 0.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset (count -> 0)
//   inc  - one-cycle increment enable
//   cnt  - current count, always within 0..MAX
//   wrap - high in the cycle an increment takes the count from MAX to 0
module mod_counter #(
    parameter int unsigned FW  = 6,
    parameter int unsigned MAX = 59
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [FW-1:0] cnt,
    output logic          wrap
);

    assign wrap = inc && (cnt == FW'(MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// Timekeeping controller for the lab3 stopwatch: holds minutes:seconds,
// advances on 1 Hz ticks, handles pause/resume and manual adjust, and
// produces per-field blink flags for the seven-segment driver.
// Ports:
//   clk, reset          - system clock, asynchronous active-high reset
//   count_tick          - 1 Hz one-cycle enable (count mode advance)
//   adj_tick            - 2 Hz one-cycle enable (adjust mode increment)
//   blink_tick          - 4 Hz one-cycle enable (blink phase toggle)
//   pause, adj, sel     - debounced button/switch levels
//   min, sec            - current time fields
//   blink_min/blink_sec - registered blanking flags for the display
//   running             - 1 while counting is enabled
module stopwatch_core
    import stopwatch_core_pkg::run_state_t;
    import stopwatch_core_pkg::ST_RUN;
    import stopwatch_core_pkg::ST_PAUSED;
    import stopwatch_core_pkg::SEL_MIN;
    import stopwatch_core_pkg::SEL_SEC;
#(
    parameter int unsigned MAX_MIN = stopwatch_core_pkg::MAX_MIN,
    parameter int unsigned MAX_SEC = stopwatch_core_pkg::MAX_SEC,
    parameter int unsigned FW      = stopwatch_core_pkg::FW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          count_tick,
    input  logic          adj_tick,
    input  logic          blink_tick,
    input  logic          pause,
    input  logic          adj,
    input  logic          sel,
    output logic [FW-1:0] min,
    output logic [FW-1:0] sec,
    output logic          blink_min,
    output logic          blink_sec,
    output logic          running
);

    run_state_t state_q, state_d;
    logic       pause_q;
    logic       pause_rise;
    logic       phase_q, phase_d;
    logic       sec_inc, min_inc;
    logic       sec_wrap;
    // Full 59:59 -> 00:00 rollover needs no further action.
    logic       min_wrap_unused;

    // Run/pause FSM state register plus pause edge and blink phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_RUN;
            pause_q   <= 1'b0;
            phase_q   <= 1'b0;
            blink_min <= 1'b0;
            blink_sec <= 1'b0;
        end else begin
            state_q   <= state_d;
            pause_q   <= pause;
            phase_q   <= phase_d;
            // Built from the next phase so blanking follows the tick by one clk.
            blink_min <= adj && (sel == SEL_MIN) && phase_d;
            blink_sec <= adj && (sel == SEL_SEC) && phase_d;
        end
    end

    always_comb begin
        pause_rise = pause && !pause_q;
        state_d    = state_q;
        if (pause_rise) begin
            state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
        end

        sec_inc = 1'b0;
        min_inc = 1'b0;
        if (adj) begin
            // Adjust: only the selected field moves, no carry between fields.
            sec_inc = adj_tick && (sel == SEL_SEC);
            min_inc = adj_tick && (sel == SEL_MIN);
        end else begin
            sec_inc = count_tick && (state_q == ST_RUN);
            min_inc = sec_wrap;
        end

        phase_d = adj ? (phase_q ^ blink_tick) : 1'b0;
    end

    assign running = (state_q == ST_RUN);

    mod_counter #(
        .FW  (FW),
        .MAX (MAX_SEC)
    ) u_sec (
        .clk  (clk),
        .rst  (reset),
        .inc  (sec_inc),
        .cnt  (sec),
        .wrap (sec_wrap)
    );

    mod_counter #(
        .FW  (FW),
        .MAX (MAX_MIN)
    ) u_min (
        .clk  (clk),
        .rst  (reset),
        .inc  (min_inc),
        .cnt  (min),
        .wrap (min_wrap_unused)
    );

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench for stopwatch_core: the driver steps an arithmetic
// reference model each cycle and queues the expected outputs; the monitor
// samples the DUT after every clock (or async reset) edge and compares.
module tb_stopwatch_core;

    localparam int FW   = 6;
    localparam int MAXM = 59;
    localparam int MAXS = 59;

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic          count_tick = 1'b0;
    logic          adj_tick   = 1'b0;
    logic          blink_tick = 1'b0;
    logic          pause      = 1'b0;
    logic          adj        = 1'b0;
    logic          sel        = 1'b0;
    logic [FW-1:0] min, sec;
    logic          blink_min, blink_sec, running;

    always #5 clk = ~clk;

    stopwatch_core #(
        .MAX_MIN (MAXM),
        .MAX_SEC (MAXS),
        .FW      (FW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .count_tick (count_tick),
        .adj_tick   (adj_tick),
        .blink_tick (blink_tick),
        .pause      (pause),
        .adj        (adj),
        .sel        (sel),
        .min        (min),
        .sec        (sec),
        .blink_min  (blink_min),
        .blink_sec  (blink_sec),
        .running    (running)
    );

    typedef struct {
        int mn;
        int sc;
        bit bm;
        bit bs;
        bit run;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state (written only by the stimulus process).
    int m_min = 0;
    int m_sec = 0;
    bit m_run = 1'b1;
    bit m_pq  = 1'b0;
    bit m_phase = 1'b0;
    bit m_adj = 1'b0;
    bit m_sel = 1'b0;

    // Held input levels for directed stimulus.
    bit lv_p = 1'b0;
    bit lv_a = 1'b0;
    bit lv_s = 1'b0;

    bit stim_done = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic model_reset();
        m_min   = 0;
        m_sec   = 0;
        m_run   = 1'b1;
        m_pq    = 1'b0;
        m_phase = 1'b0;
        m_adj   = 1'b0;
        m_sel   = 1'b0;
    endtask

    // One clock of the stopwatch rules, evaluated on pre-edge state.
    task automatic model_step(bit ct, bit at, bit bt, bit p, bit a, bit s);
        bit rise;
        int total;
        rise = p && !m_pq;
        if (!a) begin
            if (ct && m_run) begin
                total = m_min * (MAXS + 1) + m_sec + 1;
                total = total % ((MAXM + 1) * (MAXS + 1));
                m_min = total / (MAXS + 1);
                m_sec = total % (MAXS + 1);
            end
        end else if (at) begin
            if (s) m_sec = (m_sec + 1) % (MAXS + 1);
            else   m_min = (m_min + 1) % (MAXM + 1);
        end
        if (rise) m_run = !m_run;
        m_pq    = p;
        m_phase = a ? (m_phase ^ bt) : 1'b0;
        m_adj   = a;
        m_sel   = s;
    endtask

    task automatic push_exp();
        exp_t e;
        e.mn  = m_min;
        e.sc  = m_sec;
        e.bm  = m_adj && !m_sel && m_phase;
        e.bs  = m_adj && m_sel && m_phase;
        e.run = m_run;
        exp_q.push_back(e);
    endtask

    task automatic drive_cycle(bit r, bit ct, bit at, bit bt, bit p, bit a, bit s);
        @(negedge clk);
        reset      = r;
        count_tick = ct;
        adj_tick   = at;
        blink_tick = bt;
        pause      = p;
        adj        = a;
        sel        = s;
        if (r) model_reset();
        else   model_step(ct, at, bt, p, a, s);
        push_exp();
    endtask

    task automatic cyc(bit ct, bit at, bit bt);
        drive_cycle(1'b0, ct, at, bt, lv_p, lv_a, lv_s);
    endtask

    // Raise reset between clock edges; the monitor samples before the next edge.
    task automatic async_reset_mid_cycle();
        @(negedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        push_exp();
    endtask

    task automatic check(string name, logic [31:0] got, logic [31:0] expv);
        n_checks++;
        if (got !== expv)
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, expv, $time);
        else
            n_pass++;
    endtask

    // Monitor: compare every queued expectation after its edge.
    initial begin
        exp_t e;
        while (!(stim_done && exp_q.size() == 0)) begin
            @(posedge clk or posedge reset);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("min",       {26'b0, min},       e.mn);
                check("sec",       {26'b0, sec},       e.sc);
                check("blink_min", {31'b0, blink_min}, {31'b0, e.bm});
                check("blink_sec", {31'b0, blink_sec}, {31'b0, e.bs});
                check("running",   {31'b0, running},   {31'b0, e.run});
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Stimulus
    initial begin
        drive_cycle(1'b1, 0, 0, 0, 0, 0, 0);
        drive_cycle(1'b1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0);

        // 61 count ticks -> 01:01
        repeat (61) begin
            cyc(1, 0, 0);
            cyc(0, 0, 0);
        end

        // Preload 59:58 through adjust, then full wrap in count mode
        lv_a = 1'b1; lv_s = 1'b0;
        while (m_min != MAXM) cyc(0, 1, 0);
        lv_s = 1'b1;
        while (m_sec != MAXS - 1) cyc(0, 1, 0);
        lv_a = 1'b0;
        cyc(0, 0, 0);
        repeat (2) cyc(1, 0, 0);

        // Pause held high toggles once; ticks ignored; second edge resumes
        lv_p = 1'b1;
        repeat (10) cyc(0, 0, 0);
        lv_p = 1'b0;
        repeat (5) cyc(1, 0, 0);
        lv_p = 1'b1;
        cyc(0, 0, 0);
        lv_p = 1'b0;
        repeat (3) cyc(1, 0, 0);

        // Adjust seconds 59 -> 0 without carry, then minutes +3; count ticks ignored
        lv_a = 1'b1; lv_s = 1'b1;
        while (m_sec != MAXS) cyc(1, 1, 0);
        cyc(1, 1, 0);
        lv_s = 1'b0;
        repeat (3) cyc(1, 1, 0);

        // Blink phase on minutes, sel change with adj_tick, then leave adjust
        repeat (4) begin
            cyc(0, 0, 1);
            cyc(0, 0, 0);
        end
        lv_s = 1'b1;
        cyc(0, 1, 1);
        cyc(0, 0, 0);
        lv_a = 1'b0;
        cyc(0, 0, 0);

        // Pause edge coincident with count tick at 00:10
        drive_cycle(1'b1, 0, 0, 0, 0, 0, 0);
        lv_p = 1'b0; lv_a = 1'b0; lv_s = 1'b0;
        repeat (10) cyc(1, 0, 0);
        lv_p = 1'b1;
        cyc(1, 0, 0);
        lv_p = 1'b0;
        cyc(1, 0, 0);
        lv_p = 1'b1;
        cyc(0, 0, 0);
        lv_p = 1'b0;
        // adj still high on the edge where the count tick arrives
        lv_a = 1'b1;
        cyc(1, 0, 0);
        lv_a = 1'b0;
        cyc(1, 0, 0);

        // Reset asserted mid-adjust
        lv_a = 1'b1;
        repeat (3) cyc(0, 1, 1);
        async_reset_mid_cycle();
        drive_cycle(1'b1, 0, 1, 1, 0, 1, 0);
        lv_a = 1'b0;
        cyc(0, 0, 0);

        // Randomized traffic
        repeat (3000) begin
            if ($urandom_range(0, 29) == 0) lv_a = ~lv_a;
            if ($urandom_range(0, 7) == 0)  lv_s = ~lv_s;
            if ($urandom_range(0, 9) == 0)  lv_p = ~lv_p;
            if ($urandom_range(0, 699) == 0) begin
                async_reset_mid_cycle();
            end else begin
                drive_cycle(($urandom_range(0, 399) == 0),
                            ($urandom_range(0, 1) == 0),
                            ($urandom_range(0, 2) == 0),
                            ($urandom_range(0, 2) == 0),
                            lv_p, lv_a, lv_s);
            end
        end

        drive_cycle(1'b0, 0, 0, 0, 0, 0, 0);
        stim_done = 1'b1;

        repeat (200) @(posedge clk);
        $display("FAIL watchdog: monitor still holds %0d expectations, required 0", exp_q.size());
        $fatal(1, "monitor did not drain");
    end

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
Timekeeping controller for the lab3 stopwatch. It sits downstream of the debouncers and the clock divider's tick outputs, and upstream of the seven-segment display driver. It holds the minutes:seconds count and advances it on 1 Hz ticks. It also handles pause/resume and the manual adjust mode, and produces per-field blink flags for the display stage. The whole block is single-clock: divider outputs enter as one-cycle enables, not as clocks.

Parameters:
MAX_MIN, 59, highest minutes value before wrap to 0
MAX_SEC, 59, highest seconds value before wrap to 0
FW, 6, width of each time field in bits

Ports:
clk  input  1  system clock (100 MHz board clock)
reset  input  1  asynchronous, active-high reset
count_tick  input  1  one-cycle enable at 1 Hz from the divider
adj_tick  input  1  one-cycle enable at 2 Hz from the divider
blink_tick  input  1  one-cycle enable at 4 Hz from the divider
pause  input  1  debounced pause button level
adj  input  1  debounced adjust switch level; 1 = adjust mode
sel  input  1  debounced select switch level; 0 = minutes, 1 = seconds
min  output  FW  minutes value, 0..MAX_MIN
sec  output  FW  seconds value, 0..MAX_SEC
blink_min  output  1  1 = display blanks the minutes digits this cycle
blink_sec  output  1  1 = display blanks the seconds digits this cycle
running  output  1  1 = counting enabled (not paused)

Behaviour:
- Reset (async assert, sync release): min=0, sec=0, running=1, blink_min=0, blink_sec=0, blink phase=0, pause edge register=0.
- Pause edge detect: a registered copy of pause is kept. Rising edge = pause & ~pause_q. Each rising edge toggles running, taking effect the next cycle. Holding pause high toggles only once.
- Count mode (adj=0):
  - On count_tick with running=1: sec += 1.
  - If sec==MAX_SEC: sec becomes 0 and min += 1.
  - If min==MAX_MIN as well: min becomes 0, so the count wraps 59:59 -> 00:00.
  - With running=0, count_tick is ignored.
- Adjust mode (adj=1):
  - count_tick is ignored regardless of running.
  - On adj_tick, the selected field increments by 1 and wraps MAX->0 with no carry into the other field.
  - running is unaffected, and pause edges still toggle it.
- Blink:
  - The phase register toggles on every blink_tick while adj=1 and is held at 0 while adj=0.
  - blink_min = adj & ~sel & phase; blink_sec = adj & sel & phase. Both outputs are registered.
- Simultaneous events, resolved against pre-edge state:
  - pause edge and count_tick in the same cycle: the tick is evaluated with the current running value, so a running watch still counts that tick, then pauses.
  - adj falling in the same cycle as count_tick: the tick is evaluated with the current adj value and is ignored.
  - sel change in the same cycle as adj_tick: the new sel value selects the field.
- Field values are never outside 0..MAX; there is no saturation path.
- Latency: outputs update one clk after the qualifying tick.
- Reset asserted mid-count or mid-adjust returns everything to reset values immediately.

Decomposition:
- Shared package: FW, MAX_MIN, MAX_SEC, and the sel encoding constants SEL_MIN=0 and SEL_SEC=1.
- One sub-module, mod_counter: FW-bit wrap-at-MAX counter with an inc enable and a wrap output. It is instantiated twice, with the seconds wrap output feeding the minutes inc in count mode.
- FSM, edge detect and blink logic stay in the top of the block.

Test Plan:
- Reset, then 61 count_ticks with adj=0 -> min=1, sec=1, running=1.
- Preload 59:58 via adjust, set adj=0, apply 2 count_ticks -> 00:00 (full wrap).
- Pause rising edge held high for 10 cycles, then 5 count_ticks -> running=0, time unchanged. Second edge plus 3 ticks -> sec advances by 3.
- adj=1, sel=1, sec=59, one adj_tick -> sec=0 and min unchanged. sel=0, 3 adj_ticks -> min+3. count_ticks ignored throughout.
- adj=1, sel=0, 4 blink_ticks -> blink_min sequence 1,0,1,0 and blink_sec=0. adj=0 -> both blink outputs 0 the next cycle.
- Pause edge and count_tick in the same cycle while running at 00:10 -> 00:11, then running=0. Reset asserted mid-adjust -> 00:00 asynchronously.
